// File: rtl/ins_trace_buffer_if.sv
// Readout port of the instruction trace buffer: oldest stored word with a valid/ready handshake.
interface ins_trace_buffer_if;
   logic [15:0] o_DATA;
   logic        o_VALID;
   logic        i_READY;

   modport master (output o_DATA, output o_VALID, input i_READY);
   modport slave  (input o_DATA, input o_VALID, output i_READY);
endinterface

// File: rtl/ins_trace_buffer.sv
// Instruction trace buffer: arm/trigger capture of fetched words into a circular FIFO.
// Optional macro TRACE_TIMESTAMP_EN adds o_STAMP and a per-entry fetch-count stamp.
//
// state | meaning
// IDLE  | no capture, waiting for i_ARM
// ARMED | pre-trigger history; full FIFO discards oldest entry
// POST  | capturing POST_CNT words after the trigger; full FIFO drops new word
// DONE  | capture finished, waiting for i_ARM
module ins_trace_buffer #(
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int POST_CNT = 8
) (
   input  logic          i_CLOCK,
   input  logic          i_RESET_N,
   input  logic          i_CYCLEX,
   input  logic [15:0]   i_INS,
   input  logic          i_ARM,
   input  logic          i_STOP,
   input  logic          i_TRIG_EN,
   input  logic [15:0]   i_TRIG_INS,
   ins_trace_buffer_if.master trace,
   output logic [AW:0]   o_COUNT,
   output logic          o_OVF,
   output logic [1:0]    o_STATE
`ifdef TRACE_TIMESTAMP_EN
   ,
   output logic [15:0]   o_STAMP
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [7:0]  LP_POST  = 8'(POST_CNT);
   localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);
   localparam logic [AW:0] LP_CNT_ONE = (AW+1)'(1);

   state_t          r_state;
   state_t          w_state_nx;
   logic            r_cyclex_q;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic            r_ovf;
   logic [7:0]      r_post;
   logic [15:0]     r_mem [DEPTH];

   logic w_fetch;
   logic w_cap;
   logic w_full;
   logic w_rd;
   logic w_wr;
   logic w_evict;
   logic w_drop;
   logic w_inc;
   logic w_post_load;
   logic w_post_dec;
   logic w_ovf_clr;

   assign w_fetch = i_CYCLEX & ~r_cyclex_q;
   assign w_cap   = w_fetch & ((r_state == S_ARMED) | (r_state == S_POST));
   assign w_full  = (r_count == LP_DEPTH);
   assign w_rd    = (r_count != '0) & trace.i_READY;

   // A full ring in ARMED overwrites the oldest slot (wr_ptr == rd_ptr when full).
   assign w_evict = w_cap & w_full & ~w_rd & (r_state == S_ARMED);
   assign w_drop  = w_cap & w_full & ~w_rd & (r_state == S_POST);
   assign w_wr    = w_cap & ~w_drop;
   assign w_inc   = w_wr & ~w_evict;

   always_comb begin
      w_state_nx  = r_state;
      w_post_load = 1'b0;
      w_post_dec  = 1'b0;
      w_ovf_clr   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_ARM) begin
               w_state_nx = S_ARMED;
               w_ovf_clr  = 1'b1;
            end
         end
         S_ARMED: begin
            if (w_cap && i_TRIG_EN && (i_INS == i_TRIG_INS)) begin
               w_post_load = 1'b1;
               w_state_nx  = (LP_POST == 8'd0) ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            if (w_cap) begin
               w_post_dec = 1'b1;
               if (r_post == 8'd1) w_state_nx = S_DONE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
      if (i_STOP) begin
         w_state_nx = S_IDLE;
         w_ovf_clr  = 1'b0;
      end
   end

   always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
         r_state    <= S_IDLE;
         r_cyclex_q <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
         r_post     <= 8'd0;
      end else begin
         r_state    <= w_state_nx;
         r_cyclex_q <= i_CYCLEX;
         if (w_wr)            r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
         if (w_rd || w_evict) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         if (w_inc && !w_rd)      r_count <= r_count + LP_CNT_ONE;
         else if (!w_inc && w_rd) r_count <= r_count - LP_CNT_ONE;
         if (w_evict || w_drop) r_ovf <= 1'b1;
         else if (w_ovf_clr)    r_ovf <= 1'b0;
         if (w_post_load)     r_post <= LP_POST;
         else if (w_post_dec) r_post <= r_post - 8'd1;
      end
   end

   always_ff @(posedge i_CLOCK) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_INS;
   end

   assign trace.o_DATA  = (r_count != '0) ? r_mem[r_rd_ptr] : 16'h0000;
   assign trace.o_VALID = (r_count != '0);
   assign o_COUNT       = r_count;
   assign o_OVF         = r_ovf;
   assign o_STATE       = r_state;

`ifdef TRACE_TIMESTAMP_EN
   logic [15:0] r_fetch_cnt;
   logic [15:0] r_stamp_mem [DEPTH];

   always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
      if (!i_RESET_N)   r_fetch_cnt <= 16'h0000;
      else if (w_fetch) r_fetch_cnt <= r_fetch_cnt + 16'h0001;
   end

   always_ff @(posedge i_CLOCK) begin
      if (w_wr) r_stamp_mem[r_wr_ptr] <= r_fetch_cnt;
   end

   assign o_STAMP = (r_count != '0) ? r_stamp_mem[r_rd_ptr] : 16'h0000;
`endif

endmodule

// File: tb/tb_ins_trace_buffer.sv
// Scoreboard bench for ins_trace_buffer: queue-based reference model plus a negedge monitor.
module tb_ins_trace_buffer;
   localparam int DEPTH    = 16;
   localparam int AW       = 4;
   localparam int POST_CNT = 8;
   localparam logic [15:0] TRIG = 16'hBEEF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cyc = 1'b0;
   logic [15:0]   ins = 16'h0000;
   logic          arm = 1'b0;
   logic          stop = 1'b0;
   logic          trig_en = 1'b0;
   logic [AW:0]   count;
   logic          ovf;
   logic [1:0]    state;
`ifdef TRACE_TIMESTAMP_EN
   logic [15:0]   stamp;
`endif

   ins_trace_buffer_if trc();

   ins_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .POST_CNT(POST_CNT)) dut (
      .i_CLOCK    (clk),
      .i_RESET_N  (rst_n),
      .i_CYCLEX   (cyc),
      .i_INS      (ins),
      .i_ARM      (arm),
      .i_STOP     (stop),
      .i_TRIG_EN  (trig_en),
      .i_TRIG_INS (TRIG),
      .trace      (trc.master),
      .o_COUNT    (count),
      .o_OVF      (ovf),
      .o_STATE    (state)
`ifdef TRACE_TIMESTAMP_EN
      ,
      .o_STAMP    (stamp)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue of {stamp, word}; state as 0..3.
   logic [31:0] exp_q[$];
   int          m_st = 0;
   int          m_pc = 0;
   logic        m_ovf = 1'b0;
   logic        m_prev = 1'b0;
   logic [15:0] m_fcnt = 16'h0000;
   logic        rd_now = 1'b0;

   task automatic model_step();
      bit   fetch;
      int   pre;
      int   nst;
      logic [31:0] junk;
      fetch  = cyc && !m_prev;
      m_prev = cyc;
      nst    = m_st;
      pre    = exp_q.size() + (rd_now ? 1 : 0);
      if (fetch && (m_st == 1 || m_st == 2)) begin
         if (pre < DEPTH || rd_now) begin
            exp_q.push_back({m_fcnt, ins});
         end else if (m_st == 1) begin
            junk = exp_q.pop_front();
            exp_q.push_back({m_fcnt, ins});
            m_ovf = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
         if (m_st == 1 && trig_en && ins == TRIG) begin
            m_pc = POST_CNT;
            nst  = (POST_CNT == 0) ? 3 : 2;
         end else if (m_st == 2) begin
            m_pc = m_pc - 1;
            if (m_pc == 0) nst = 3;
         end
      end
      if (fetch) m_fcnt = m_fcnt + 16'h0001;
      if (stop) nst = 0;
      else if ((m_st == 0 || m_st == 3) && arm) begin
         nst   = 1;
         m_ovf = 1'b0;
      end
      m_st = nst;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_st   = 0;
      m_pc   = 0;
      m_ovf  = 1'b0;
      m_prev = 1'b0;
      m_fcnt = 16'h0000;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   task automatic monitor_step();
      logic [31:0] item;
      if (!rst_n) begin
         rd_now = 1'b0;
         return;
      end
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("valid", 32'(trc.o_VALID), 32'(exp_q.size() != 0));
      chk("state", 32'(state), 32'(m_st));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      rd_now = (exp_q.size() != 0) && trc.i_READY;
      if (rd_now) begin
         item = exp_q.pop_front();
         chk("data", 32'(trc.o_DATA), 32'(item[15:0]));
`ifdef TRACE_TIMESTAMP_EN
         chk("stamp", 32'(stamp), 32'(item[31:16]));
`endif
      end
   endtask

   always @(negedge clk) monitor_step();

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] w, input logic r);
      ins = w;
      cyc = 1'b1;
      trc.i_READY = r;
      tick();
      cyc = 1'b0;
      trc.i_READY = 1'b0;
      tick();
   endtask

   task automatic pulse_arm();
      arm = 1'b1; tick(); arm = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic drain(input int n);
      trc.i_READY = 1'b1;
      repeat (n) tick();
      trc.i_READY = 1'b0;
   endtask

   initial begin
      trc.i_READY = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc = ~cyc;
         tick();
      end
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(trc.o_VALID), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      cyc = 1'b0;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 3; i++) fetch(16'h5555, 1'b0);
      chk("idle_nocap", 32'(count), 32'd0);

      // Long X-cycle strobe yields a single capture.
      pulse_arm();
      ins = 16'h1234;
      cyc = 1'b1;
      repeat (3) tick();
      cyc = 1'b0;
      tick();
      chk("long_cyc_count", 32'(count), 32'd1);
      chk("long_cyc_data", 32'(trc.o_DATA), 32'h1234);
      drain(4);

      // Pre-trigger ring overflow.
      pulse_stop();
      trig_en = 1'b0;
      pulse_arm();
      for (int i = 0; i < 20; i++) fetch(16'(i), 1'b0);
      chk("ring_count", 32'(count), 32'd16);
      chk("ring_ovf", 32'(ovf), 32'd1);
      chk("ring_oldest", 32'(trc.o_DATA), 32'h0004);
      drain(20);

      // Trigger then POST_CNT words.
      pulse_stop();
      trig_en = 1'b1;
      pulse_arm();
      fetch(16'h0001, 1'b0);
      fetch(16'h0002, 1'b0);
      fetch(TRIG, 1'b0);
      chk("trig_post", 32'(state), 32'd2);
      for (int i = 0; i < 11; i++) fetch(16'h0100 + 16'(i), 1'b0);
      chk("trig_done", 32'(state), 32'd3);
      chk("trig_count", 32'(count), 32'd11);
      drain(20);

      // Full in POST: read+write keeps everything, write alone drops.
      pulse_stop();
      pulse_arm();
      for (int i = 0; i < 9; i++) fetch(16'h0200 + 16'(i), 1'b0);
      fetch(TRIG, 1'b0);
      for (int i = 0; i < 6; i++) fetch(16'h0300 + 16'(i), 1'b0);
      chk("post_full_count", 32'(count), 32'd16);
      fetch(16'h0306, 1'b1);
      chk("post_rw_ovf", 32'(ovf), 32'd0);
      chk("post_rw_count", 32'(count), 32'd16);
      fetch(16'h0307, 1'b0);
      chk("post_drop_ovf", 32'(ovf), 32'd1);
      chk("post_drop_state", 32'(state), 32'd3);
      drain(20);

      // Asynchronous reset mid-POST.
      pulse_stop();
      pulse_arm();
      fetch(16'h0AAA, 1'b0);
      fetch(16'h0BBB, 1'b0);
      fetch(TRIG, 1'b0);
      fetch(16'h0401, 1'b0);
      fetch(16'h0402, 1'b0);
      chk("pre_async_count", 32'(count), 32'd5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_valid", 32'(trc.o_VALID), 32'd0);
      chk("async_data", 32'(trc.o_DATA), 32'd0);
      chk("async_ovf", 32'(ovf), 32'd0);
      chk("async_state", 32'(state), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk("post_rst_state", 32'(state), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc         = 1'($urandom_range(0, 1));
         ins         = ($urandom_range(0, 7) == 0) ? TRIG : 16'($urandom);
         arm         = ($urandom_range(0, 40) == 0);
         stop        = ($urandom_range(0, 120) == 0);
         trig_en     = ($urandom_range(0, 3) != 0);
         trc.i_READY = ($urandom_range(0, 2) == 0);
         tick();
      end
      arm = 1'b0;
      cyc = 1'b0;
      pulse_stop();
      drain(20);
      chk("final_empty", 32'(count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
